// File: rtl/spi_slave_sync.sv
// SPI slave running entirely in the clk_sys domain: the pins are oversampled through
// synchronisers, and the slave hands off received/transmitted words over ready/valid handshakes.
module spi_slave_sync #(
    parameter int unsigned       DATA_W      = 8,
    parameter bit                CPOL        = 1'b0,
    parameter bit                CPHA        = 1'b0,
    parameter bit                MSB_FIRST   = 1'b1,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] FILL        = '1
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              overrun,
    output logic              underrun,
    output logic              busy
);

    localparam int unsigned     CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] clk_sync, cs_sync, mosi_sync;
    logic                   s_clk, s_cs_n, s_mosi;
    logic                   s_clk_d, s_cs_n_d;
    logic                   busy_q;

    logic                   lead_edge, trail_edge, sample_edge, shift_edge;
    logic                   cs_fall, cs_rise;

    state_t                 state, state_next;
    logic                   load, abort, sample_en, shift_en;

    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      rx_sr, rx_word;
    logic                   word_done;
    logic [DATA_W-1:0]      tx_sr, hold;

    assign s_clk  = clk_sync[SYNC_STAGES-1];
    assign s_cs_n = cs_sync[SYNC_STAGES-1];
    assign s_mosi = mosi_sync[SYNC_STAGES-1];

    // Pin synchronisers plus one extra stage on clk/cs for edge detection.
    // busy is taken from the stage before s_cs_n so that it equals ~s_cs_n as a flop.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            clk_sync  <= {SYNC_STAGES{CPOL}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            s_clk_d   <= CPOL;
            s_cs_n_d  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            s_clk_d   <= s_clk;
            s_cs_n_d  <= s_cs_n;
            busy_q    <= ~cs_sync[SYNC_STAGES-2];
        end
    end

    assign busy        = busy_q;
    assign spi_miso_oe = busy_q;

    assign lead_edge   = (s_clk != s_clk_d) && !s_cs_n && (s_clk != CPOL);
    assign trail_edge  = (s_clk != s_clk_d) && !s_cs_n && (s_clk == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = s_cs_n_d && !s_cs_n;
    assign cs_rise     = !s_cs_n_d && s_cs_n;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A shift edge with the counter at 0 is the word boundary in both CPHA modes:
    // for CPHA=0 the counter has already advanced on the leading edge of every bit but the wrap.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        abort      = 1'b0;
        sample_en  = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = ACTIVE;
                    load       = !CPHA;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else begin
                    sample_en = sample_edge;
                    if (shift_edge) begin
                        if (bit_cnt == '0) begin
                            load = 1'b1;
                        end else begin
                            shift_en = 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx_word   = MSB_FIRST ? {rx_sr[DATA_W-2:0], s_mosi} : {s_mosi, rx_sr[DATA_W-1:1]};
    assign word_done = sample_en && (bit_cnt == LAST);

    // Receive path: bit counter, shift register and single-entry output handshake.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            bit_cnt  <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (abort) begin
                bit_cnt <= '0;
                rx_sr   <= '0;
            end else if (sample_en) begin
                rx_sr   <= rx_word;
                bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CNT_W'(1);
            end
            if (word_done) begin
                if (rx_valid && !rx_ready) begin
                    overrun <= 1'b1;
                end else begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Transmit path: holding register feeds the shift register at each load point.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            tx_sr    <= '0;
            hold     <= '0;
            tx_ready <= 1'b1;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (abort) begin
                tx_sr <= '0;
            end else if (load) begin
                if (!tx_ready) begin
                    tx_sr <= hold;
                end else begin
                    tx_sr    <= FILL;
                    underrun <= 1'b1;
                end
            end else if (shift_en) begin
                tx_sr <= MSB_FIRST ? {tx_sr[DATA_W-2:0], 1'b0} : {1'b0, tx_sr[DATA_W-1:1]};
            end
            if (tx_valid && tx_ready) begin
                hold     <= tx_data;
                tx_ready <= 1'b0;
            end else if (load && !tx_ready) begin
                tx_ready <= 1'b1;
            end
        end
    end

    // tx_sr is cleared outside a transfer, so MISO idles low.
    assign spi_miso = MSB_FIRST ? tx_sr[DATA_W-1] : tx_sr[0];

endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Parametrised SPI slave that runs entirely in the `clk_sys` domain. It oversamples `spi_clk`, `spi_cs_n` and `spi_mosi` through synchronisers and supports all four CPOL/CPHA modes, a configurable word width and bit order. It has full-duplex operation with ready/valid handshakes on both the receive and transmit sides. It sits between the external SPI pins and the system-side register or command logic, and needs no second clock domain.

## Interface
Parameters:
- `DATA_W`, 8, word width in bits (≥ 2)
- `CPOL`, 0, idle level of `spi_clk`
- `CPHA`, 0, 0 = sample on leading edge; 1 = sample on trailing edge
- `MSB_FIRST`, 1, 1 = MSB shifted first; 0 = LSB first
- `SYNC_STAGES`, 2, synchroniser depth on each pin input (≥ 2)
- `FILL`, all-ones, word shifted out on transmit underrun

Ports (one clock; reset is synchronous and active-high):
- `clk_sys`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `spi_clk`  in  1  SPI clock pin, asynchronous
- `spi_cs_n`  in  1  chip select pin, active low, asynchronous
- `spi_mosi`  in  1  MOSI pin, asynchronous
- `spi_miso`  out  1  MISO data, registered
- `spi_miso_oe`  out  1  MISO output enable, high while selected
- `rx_data`  out  DATA_W  received word
- `rx_valid`  out  1  `rx_data` holds an unconsumed word
- `rx_ready`  in  1  consumer accepts `rx_data`
- `tx_data`  in  DATA_W  next word to transmit
- `tx_valid`  in  1  `tx_data` offered
- `tx_ready`  out  1  transmit holding register empty
- `overrun`  out  1  one-cycle pulse: a received word was dropped
- `underrun`  out  1  one-cycle pulse: `FILL` was loaded for transmit
- `busy`  out  1  synchronised CS asserted

## Operation
- Pin inputs pass through `SYNC_STAGES` flops each, giving `s_clk`, `s_cs_n` and `s_mosi`. A further flop on `s_clk` and `s_cs_n` is used for edge detection.
- Leading edge = `s_clk` leaves `CPOL`. Trailing edge = `s_clk` returns to `CPOL`. The sample edge is leading if `CPHA`=0, otherwise trailing. The shift edge is the other one.
- Edges count only while `s_cs_n`=0.
- States:
  - IDLE: `s_cs_n`=1.
  - ACTIVE: entered on the synchronised CS fall, left on the synchronised CS rise.
- A bit counter (0..DATA_W-1) advances on each sample edge. Each sample edge shifts `s_mosi` into the receive shift register.
  - When the counter is at DATA_W-1, the assembled word goes to `rx_data`, `rx_valid` is set, and the counter wraps to 0.
- RX handshake:
  - `rx_valid` and `rx_ready` high together clears `rx_valid`.
  - If a word completes while `rx_valid`=1 and `rx_ready`=0: the new word is dropped, `rx_data` is unchanged, and `overrun` pulses.
  - If `rx_ready`=1 in the same cycle as a completion: the old word is consumed, the new word is loaded, `rx_valid` stays 1, and there is no overrun.
- TX holding register: `tx_valid`&`tx_ready` writes `tx_data` and clears `tx_ready`.
- TX load point:
  - CPHA=0: the CS fall, and the first shift edge after each completed word.
  - CPHA=1: the shift edge with counter=0.
- At the load point:
  - Holding full: the holding word is copied into the transmit shift register and `tx_ready` sets.
  - Holding empty: `FILL` is loaded and `underrun` pulses.
- A holding write in the same cycle as the load point is kept for the next word.
- Every non-load shift edge shifts the transmit register by one bit. `spi_miso` shows its MSB (or LSB if `MSB_FIRST`=0).
- `spi_miso_oe` = `busy` = ~`s_cs_n`. `spi_miso` is 0 in IDLE.
- CS rise mid-word:
  - The counter clears and the partial RX word is discarded, with no `rx_valid`.
  - The TX shift register contents are discarded. The holding register is kept.
- `rst` mid-transfer returns all state to reset values, regardless of the pins.

## Timing
- Reset values: `spi_miso`=0, `spi_miso_oe`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `overrun`=0, `underrun`=0, `busy`=0.
- Pin-to-effect latency: an edge on a pin acts SYNC_STAGES+1 `clk_sys` rising edges after the first edge that captures it.
- `rx_valid` rises SYNC_STAGES+1 cycles after the final sample edge at the pins.
- `spi_miso` changes SYNC_STAGES+1 cycles after a shift edge or CS fall. Master sample margin must cover (SYNC_STAGES+2)·T_clk_sys.
- Required: each `spi_clk` high and low phase lasts ≥ SYNC_STAGES+2 `clk_sys` periods.
- Required: CS fall to first `spi_clk` edge ≥ SYNC_STAGES+2 periods.
- Required: `s_mosi` is stable for ±1 period around the sample edge.
- `tx_ready` re-asserts the cycle after a load. `overrun` and `underrun` are exactly one cycle wide.

## Test plan
- Mode 0, DATA_W=8, MSB first; master sends 0xA5 with `tx_data`=0x3C preloaded -> `rx_data`=0xA5 with `rx_valid` pulse; master captures 0x3C.
- All four CPOL/CPHA modes, DATA_W=16, LSB first; master sends 0x1234 and slave transmits 0xBEEF -> both sides exact, `rx_valid` SYNC_STAGES+1 cycles after the last edge.
- Two back-to-back words in one CS with `rx_ready` held 0 -> first word retained, `overrun` pulses once, `rx_valid` stays 1.
- No `tx_valid` before CS fall -> MISO shifts 0xFF and `underrun` pulses; a `tx_valid` at the load point is shifted in the next word.
- CS rise after 5 bits, then a new full word 0x5A -> no `rx_valid` for the partial word, `rx_data`=0x5A afterwards.
- `rst` asserted mid-word -> all outputs at reset values the next cycle, and the next transfer receives correctly.
